sm_to_twos_serial: RTL and testbench

Bit-serial converter from sign-magnitude back to WIDTH-bit two's complement. It is the inverse of the combinational absolute-value stage on the datapath. It takes a sign bit and an unsigned magnitude, rebuilds the signed value LSB-first over WIDTH cycles, and saturates magnitudes that do not fit the signed range. It sits between magnitude-domain processing and any consumer that expects signed 16-bit words, with valid/ready on both sides.

---
 rtl/sm_pkg.sv | 26 ++
 rtl/serial_twos_cell.sv | 35 +++
 rtl/sm_to_twos_serial.sv | 121 ++++++++++++
 tb/tb_sm_to_twos_serial.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared sign-magnitude definitions: FSM states, default width, saturation
// limits and the overflow predicate used when converting back to two's complement.
package sm_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [63:0] sat_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

  // Negative side may reach 2^(width-1); positive side stops one short of it.
  function automatic logic ovf(input logic sgn, input logic [63:0] mag, input int width);
    return sgn ? (mag > sat_neg(width)) : (mag > sat_pos(width));
  endfunction

endpackage

// File: rtl/serial_twos_cell.sv
// One-bit serial negation cell: passes bits up to and including the first 1,
// then inverts every later bit when the word is negative.
module serial_twos_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic sign,
  input  logic bit_in,
  output logic out_bit
);

  logic seen_one_q;
  logic seen_one_d;

  always_comb begin
    seen_one_d = seen_one_q;
    if (clear) begin
      seen_one_d = 1'b0;
    end else if (en) begin
      seen_one_d = seen_one_q | bit_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_one_q <= 1'b0;
    end else begin
      seen_one_q <= seen_one_d;
    end
  end

  assign out_bit = bit_in ^ (sign & seen_one_q);

endmodule

// File: rtl/sm_to_twos_serial.sv
// Bit-serial sign-magnitude to two's-complement converter with saturation,
// processing one magnitude bit per cycle LSB-first behind valid/ready handshakes.
module sm_to_twos_serial
  import sm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] magnitude,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg(WIDTH));
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_sr_q, mag_sr_d;
  logic [WIDTH-1:0] res_sr_q, res_sr_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic accept;
  logic step;
  logic out_bit;

  assign accept = in_valid && (state_q == IDLE);
  assign step   = (state_q == SHIFT);

  serial_twos_cell u_cell (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept),
    .en      (step),
    .sign    (sign_q),
    .bit_in  (mag_sr_q[0]),
    .out_bit (out_bit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mag_sr_d   = mag_sr_q;
    res_sr_d   = res_sr_q;
    sign_d     = sign_q;
    ovf_d      = ovf_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_sr_d = magnitude;
          sign_d   = sign;
          ovf_d    = ovf(sign, 64'(magnitude), WIDTH);
          cnt_d    = '0;
          res_sr_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        res_sr_d = {out_bit, res_sr_q[WIDTH-1:1]};
        mag_sr_d = mag_sr_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Final step: publish the rebuilt word, or the saturation limit.
        if (cnt_q == LAST) begin
          state_d    = DONE;
          cnt_d      = '0;
          overflow_d = ovf_q;
          result_d   = ovf_q ? (sign_q ? SAT_NEG : SAT_POS) : res_sr_d;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_sr_q   <= '0;
      res_sr_q   <= '0;
      sign_q     <= 1'b0;
      ovf_q      <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mag_sr_q   <= mag_sr_d;
      res_sr_q   <= res_sr_d;
      sign_q     <= sign_d;
      ovf_q      <= ovf_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_sm_to_twos_serial.sv
// Directed and table-driven bench for the serial sign-magnitude converter,
// including hold in DONE, mid-conversion reset and a back-to-back random stream.
module tb_sm_to_twos_serial;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [WIDTH-1:0] magnitude;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic        sgn;
    logic [15:0] mag;
    logic [15:0] exp_res;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[12];

  sm_to_twos_serial #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .magnitude (magnitude),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic void refModel(input logic s, input logic [15:0] m,
                                   output logic [15:0] res, output logic ov);
    if (!s) begin
      ov  = (m > 16'h7FFF);
      res = ov ? 16'h7FFF : m;
    end else begin
      ov  = (m > 16'h8000);
      res = ov ? 16'h8000 : (16'h0000 - m);
    end
  endfunction

  // Called at a negedge; returns the posedge number on which the word is accepted.
  task automatic applyStimulus(input logic s, input logic [15:0] m, output int accept_cyc);
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    sign       = s;
    magnitude  = m;
    accept_cyc = cyc + 1;
    @(negedge clk);
    in_valid  = 1'b0;
    sign      = ~s;
    magnitude = ~m;
  endtask

  task automatic waitValid(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL out_valid_timeout actual=none required=out_valid within %0d cycles", budget);
    end
  endtask

  initial begin
    int          acc;
    int          prev_acc;
    int          lat;
    bit          ok;
    int          seen;
    logic [15:0] m_r;
    logic        s_r;
    logic [15:0] exp_r;
    logic        exp_o;

    vecs[0]  = '{1'b0, 16'h0005, 16'h0005, 1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 16'hFFFB, 1'b0};
    vecs[2]  = '{1'b1, 16'h8000, 16'h8000, 1'b0};
    vecs[3]  = '{1'b1, 16'h0000, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 16'h8000, 16'h7FFF, 1'b1};
    vecs[5]  = '{1'b1, 16'h9000, 16'h8000, 1'b1};
    vecs[6]  = '{1'b0, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[7]  = '{1'b1, 16'h7FFF, 16'h8001, 1'b0};
    vecs[8]  = '{1'b1, 16'h8001, 16'h8000, 1'b1};
    vecs[9]  = '{1'b0, 16'hFFFF, 16'h7FFF, 1'b1};
    vecs[10] = '{1'b1, 16'h0001, 16'hFFFF, 1'b0};
    vecs[11] = '{1'b0, 16'h0000, 16'h0000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sign      = 1'b0;
    magnitude = '0;
    out_ready = 1'b0;
    #2;
    checkOutput("reset_result",    32'(result),    32'd0);
    checkOutput("reset_overflow",  32'(overflow),  32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy",      32'(busy),      32'd0);
    checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed vector table");
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].mag, acc);
      waitValid(40, lat, ok);
      if (ok) begin
        checkOutput($sformatf("vec%0d_latency", i),  32'(lat),      32'd16);
        checkOutput($sformatf("vec%0d_result", i),   32'(result),   32'(vecs[i].exp_res));
        checkOutput($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      end
      @(negedge clk);
      checkOutput($sformatf("vec%0d_in_ready_after", i),  32'(in_ready),  32'd1);
      checkOutput($sformatf("vec%0d_out_valid_after", i), 32'(out_valid), 32'd0);
    end

    $display("[TB] hold in DONE with out_ready low");
    out_ready = 1'b0;
    applyStimulus(1'b1, 16'h0005, acc);
    waitValid(40, lat, ok);
    if (ok) checkOutput("hold_result_first", 32'(result), 32'h0000FFFB);
    for (int k = 0; k < 5; k++) begin
      in_valid  = (k % 2 == 0);
      sign      = 1'b0;
      magnitude = 16'h1111;
      @(negedge clk);
      checkOutput($sformatf("hold%0d_result", k),    32'(result),    32'h0000FFFB);
      checkOutput($sformatf("hold%0d_overflow", k),  32'(overflow),  32'd0);
      checkOutput($sformatf("hold%0d_in_ready", k),  32'(in_ready),  32'd0);
      checkOutput($sformatf("hold%0d_out_valid", k), 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("hold_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("hold_release_in_ready",  32'(in_ready),  32'd1);
    @(negedge clk);
    checkOutput("hold_no_phantom_busy", 32'(busy), 32'd0);

    $display("[TB] reset during SHIFT");
    applyStimulus(1'b0, 16'h0005, acc);
    repeat (7) @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_result",    32'(result),    32'd0);
    checkOutput("midreset_overflow",  32'(overflow),  32'd0);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_busy",      32'(busy),      32'd0);
    checkOutput("midreset_in_ready",  32'(in_ready),  32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checkOutput("post_reset_no_out_valid", 32'(seen), 32'd0);
    applyStimulus(1'b1, 16'h1234, acc);
    waitValid(40, lat, ok);
    if (ok) begin
      checkOutput("post_reset_result",   32'(result),   32'h0000EDCC);
      checkOutput("post_reset_overflow", 32'(overflow), 32'd0);
    end
    @(negedge clk);

    $display("[TB] back-to-back random stream");
    prev_acc = 0;
    for (int i = 0; i < 100; i++) begin
      s_r = 1'($urandom_range(0, 1));
      m_r = 16'($urandom);
      refModel(s_r, m_r, exp_r, exp_o);
      applyStimulus(s_r, m_r, acc);
      if (i > 0) checkOutput($sformatf("stream%0d_period", i), 32'(acc - prev_acc), 32'd18);
      prev_acc = acc;
      waitValid(40, lat, ok);
      if (ok) begin
        checkOutput($sformatf("stream%0d_result", i),   32'(result),   32'(exp_r));
        checkOutput($sformatf("stream%0d_overflow", i), 32'(overflow), 32'(exp_o));
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
